// File: rtl/noc_pkg.sv
// Shared NoC allocator definitions: default geometry, credit width, output FSM encoding.
package noc_pkg;

  localparam int unsigned NOC_IN_PORTS      = 5;
  localparam int unsigned NOC_OUT_PORTS     = 5;
  localparam int unsigned NOC_OUT_PORT_BITS = 3;
  localparam int unsigned NOC_BUF_DEPTH     = 4;
  localparam int unsigned CREDIT_W          = $clog2(NOC_BUF_DEPTH + 1);

  // Per-output wormhole state: free for arbitration, or held by one input until its tail
  typedef enum logic {
    OUT_IDLE   = 1'b0,
    OUT_LOCKED = 1'b1
  } out_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports: req[N] requests, ptr = highest-priority index;
//        gnt[N] one-hot grant (zero when no request), gnt_idx = index of the granted requester.
module rr_arbiter #(
  parameter  int unsigned N     = 5,
  localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] gnt_idx
);

  int unsigned cand;
  logic        found;

  // Scan ptr, ptr+1, ... (mod N) and take the first active request
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = 0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = (32'(ptr) + k) % N;
      if (!found && req[cand]) begin
        found        = 1'b1;
        gnt[cand]    = 1'b1;
        gnt_idx      = PTR_W'(cand);
      end
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// Per-output wormhole switch allocator with round-robin arbitration and credit flow control.
// Ports: clk, reset (async active-low), en (enable, mirrored on xbar_on);
//        req_valid/req_ports/req_tail per input; credit_ret per output;
//        grants per input (combinational), xbar_ports (req_ports pass-through),
//        out_locked per output (registered FSM state), err (registered 1-cycle violation pulse).
module switch_allocator
  import noc_pkg::*;
#(
  parameter int unsigned IN_PORTS      = NOC_IN_PORTS,
  parameter int unsigned OUT_PORTS     = NOC_OUT_PORTS,
  parameter int unsigned OUT_PORT_BITS = NOC_OUT_PORT_BITS,
  parameter int unsigned BUF_DEPTH     = NOC_BUF_DEPTH
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              en,
  input  logic [IN_PORTS-1:0]               req_valid,
  input  logic [IN_PORTS*OUT_PORT_BITS-1:0] req_ports,
  input  logic [IN_PORTS-1:0]               req_tail,
  input  logic [OUT_PORTS-1:0]              credit_ret,
  output logic [IN_PORTS-1:0]               grants,
  output logic [IN_PORTS*OUT_PORT_BITS-1:0] xbar_ports,
  output logic                              xbar_on,
  output logic [OUT_PORTS-1:0]              out_locked,
  output logic                              err
);

  localparam int unsigned IDX_W = (IN_PORTS > 1) ? $clog2(IN_PORTS) : 1;
  localparam int unsigned CW    = $clog2(BUF_DEPTH + 1);

  out_state_e         state_q  [OUT_PORTS];
  out_state_e         state_d  [OUT_PORTS];
  logic [IDX_W-1:0]   owner_q  [OUT_PORTS];
  logic [IDX_W-1:0]   owner_d  [OUT_PORTS];
  logic [IDX_W-1:0]   rr_ptr_q [OUT_PORTS];
  logic [IDX_W-1:0]   rr_ptr_d [OUT_PORTS];
  logic [CW-1:0]      credit_q [OUT_PORTS];
  logic [CW-1:0]      credit_d [OUT_PORTS];
  logic               err_q;
  logic               err_d;

  logic [OUT_PORT_BITS-1:0] port_w   [IN_PORTS];
  logic [IN_PORTS-1:0]      elig     [OUT_PORTS];
  logic [IN_PORTS-1:0]      arb_req  [OUT_PORTS];
  logic [IN_PORTS-1:0]      arb_gnt  [OUT_PORTS];
  logic [IDX_W-1:0]         arb_idx  [OUT_PORTS];
  logic [IN_PORTS-1:0]      out_gnt  [OUT_PORTS];
  logic [IDX_W-1:0]         win      [OUT_PORTS];
  logic [IN_PORTS-1:0]      owned;
  logic [IN_PORTS-1:0]      bad_port;
  logic [OUT_PORTS-1:0]     wrong_port;
  logic [OUT_PORTS-1:0]     cred_ovf;

  // Unpack requested ports, eligibility matrix and inputs already bound to a locked output
  always_comb begin
    owned = '0;
    for (int unsigned i = 0; i < IN_PORTS; i++) begin
      port_w[i]   = req_ports[i*OUT_PORT_BITS +: OUT_PORT_BITS];
      bad_port[i] = req_valid[i] && (32'(port_w[i]) >= OUT_PORTS);
    end
    for (int unsigned o = 0; o < OUT_PORTS; o++) begin
      if (state_q[o] == OUT_LOCKED) owned[owner_q[o]] = 1'b1;
    end
    for (int unsigned o = 0; o < OUT_PORTS; o++) begin
      for (int unsigned i = 0; i < IN_PORTS; i++) begin
        elig[o][i] = req_valid[i] && (port_w[i] == OUT_PORT_BITS'(o)) && (credit_q[o] != '0);
      end
      // A mid-packet owner may not win any other output
      arb_req[o]    = elig[o] & ~owned;
      wrong_port[o] = (state_q[o] == OUT_LOCKED) && req_valid[owner_q[o]] &&
                      (port_w[owner_q[o]] != OUT_PORT_BITS'(o));
    end
  end

  for (genvar g = 0; g < OUT_PORTS; g++) begin : g_arb
    rr_arbiter #(.N(IN_PORTS)) u_arb (
      .req     (arb_req[g]),
      .ptr     (rr_ptr_q[g]),
      .gnt     (arb_gnt[g]),
      .gnt_idx (arb_idx[g])
    );
  end

  // Per-output FSM next state, grant selection and credit accounting
  always_comb begin
    grants = '0;
    for (int unsigned o = 0; o < OUT_PORTS; o++) begin
      state_d[o]  = state_q[o];
      owner_d[o]  = owner_q[o];
      rr_ptr_d[o] = rr_ptr_q[o];
      credit_d[o] = credit_q[o];
      out_gnt[o]  = '0;
      win[o]      = owner_q[o];
      cred_ovf[o] = 1'b0;

      // reset gating keeps grants silent while the allocator is held in reset
      if (en && reset) begin
        if (state_q[o] == OUT_IDLE) begin
          out_gnt[o] = arb_gnt[o];
          win[o]     = arb_idx[o];
        end else if (elig[o][owner_q[o]]) begin
          out_gnt[o][owner_q[o]] = 1'b1;
        end
      end

      if (|out_gnt[o]) begin
        if (req_tail[win[o]]) begin
          state_d[o]  = OUT_IDLE;
          rr_ptr_d[o] = IDX_W'((32'(win[o]) + 1) % IN_PORTS);
        end else begin
          state_d[o] = OUT_LOCKED;
          owner_d[o] = win[o];
        end
      end

      case ({|out_gnt[o], credit_ret[o]})
        2'b10:   credit_d[o] = credit_q[o] - CW'(1);
        2'b01: begin
          if (credit_q[o] == CW'(BUF_DEPTH)) cred_ovf[o] = 1'b1;
          else                               credit_d[o] = credit_q[o] + CW'(1);
        end
        default: credit_d[o] = credit_q[o];
      endcase

      grants = grants | out_gnt[o];
    end
    err_d = (|bad_port) || (|wrong_port) || (|cred_ovf);
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned o = 0; o < OUT_PORTS; o++) begin
        state_q[o]  <= OUT_IDLE;
        owner_q[o]  <= '0;
        rr_ptr_q[o] <= '0;
        credit_q[o] <= CW'(BUF_DEPTH);
      end
      err_q <= 1'b0;
    end else begin
      for (int unsigned o = 0; o < OUT_PORTS; o++) begin
        state_q[o]  <= state_d[o];
        owner_q[o]  <= owner_d[o];
        rr_ptr_q[o] <= rr_ptr_d[o];
        credit_q[o] <= credit_d[o];
      end
      err_q <= err_d;
    end
  end

  always_comb begin
    for (int unsigned o = 0; o < OUT_PORTS; o++) begin
      out_locked[o] = (state_q[o] == OUT_LOCKED);
    end
  end

  assign xbar_ports = req_ports;
  assign xbar_on    = en;
  assign err        = err_q;

endmodule

// File: tb/tb_switch_allocator.sv
// Directed self-checking bench for switch_allocator (5x5, BUF_DEPTH=4).
module tb_switch_allocator;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [4:0]  req_valid;
  logic [14:0] req_ports;
  logic [4:0]  req_tail;
  logic [4:0]  credit_ret;
  logic [4:0]  grants;
  logic [14:0] xbar_ports;
  logic        xbar_on;
  logic [4:0]  out_locked;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  switch_allocator dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .req_valid  (req_valid),
    .req_ports  (req_ports),
    .req_tail   (req_tail),
    .credit_ret (credit_ret),
    .grants     (grants),
    .xbar_ports (xbar_ports),
    .xbar_on    (xbar_on),
    .out_locked (out_locked),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    req_valid  = '0;
    req_ports  = '0;
    req_tail   = '0;
    credit_ret = '0;
  endtask

  task automatic set_req(input int i, input logic [2:0] p, input logic tail);
    req_valid[i]       = 1'b1;
    req_ports[i*3 +: 3] = p;
    req_tail[i]        = tail;
  endtask

  task automatic clr_req(input int i);
    req_valid[i]        = 1'b0;
    req_ports[i*3 +: 3] = 3'd0;
    req_tail[i]         = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    en    = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    en    = 1'b1;
    clear_inputs();
    set_req(0, 3'd0, 1'b1);
    #1;
    if (grants !== 5'b00000) begin n_bad++; $display("FAIL reset_grants: got %b want 00000", grants); end
    n_cmp++;
    if (out_locked !== 5'b00000) begin n_bad++; $display("FAIL reset_locked: got %b want 00000", out_locked); end
    n_cmp++;
    if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
    n_cmp++;
    @(negedge clk);
    reset = 1'b1;
    #1;
    if (grants !== 5'b00001) begin n_bad++; $display("FAIL reset_first_grant: got %b want 00001", grants); end
    n_cmp++;
    if (xbar_on !== 1'b1) begin n_bad++; $display("FAIL reset_xbar_on: got %b want 1", xbar_on); end
    n_cmp++;
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_contention();
    logic [4:0] exp_g [6];
    exp_g = '{5'b00001, 5'b00100, 5'b10000, 5'b00001, 5'b00100, 5'b10000};
    do_reset();
    @(negedge clk);
    set_req(0, 3'd1, 1'b1);
    set_req(2, 3'd1, 1'b1);
    set_req(4, 3'd1, 1'b1);
    credit_ret = 5'b00010;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (grants !== exp_g[k]) begin n_bad++; $display("FAIL contention_grant%0d: got %b want %b", k, grants, exp_g[k]); end
      n_cmp++;
      @(negedge clk);
      if (err !== 1'b0) begin n_bad++; $display("FAIL contention_err%0d: got %b want 0", k, err); end
      n_cmp++;
    end
    clear_inputs();
  endtask

  task automatic test_wormhole();
    do_reset();
    @(negedge clk);
    set_req(3, 3'd2, 1'b0);
    #1;
    if (grants !== 5'b01000) begin n_bad++; $display("FAIL worm_head: got %b want 01000", grants); end
    n_cmp++;
    @(negedge clk);
    if (out_locked !== 5'b00100) begin n_bad++; $display("FAIL worm_locked_head: got %b want 00100", out_locked); end
    n_cmp++;
    set_req(1, 3'd2, 1'b1);
    #1;
    if (grants !== 5'b01000) begin n_bad++; $display("FAIL worm_body: got %b want 01000", grants); end
    n_cmp++;
    @(negedge clk);
    if (out_locked !== 5'b00100) begin n_bad++; $display("FAIL worm_locked_body: got %b want 00100", out_locked); end
    n_cmp++;
    set_req(3, 3'd2, 1'b1);
    #1;
    if (grants !== 5'b01000) begin n_bad++; $display("FAIL worm_tail: got %b want 01000", grants); end
    n_cmp++;
    @(negedge clk);
    if (out_locked !== 5'b00000) begin n_bad++; $display("FAIL worm_unlock: got %b want 00000", out_locked); end
    n_cmp++;
    clr_req(3);
    #1;
    if (grants !== 5'b00010) begin n_bad++; $display("FAIL worm_next_input: got %b want 00010", grants); end
    n_cmp++;
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_credits();
    logic       ret_s [13];
    logic       gnt_s [13];
    ret_s = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    gnt_s = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    do_reset();
    @(negedge clk);
    set_req(0, 3'd0, 1'b1);
    for (int k = 0; k < 13; k++) begin
      credit_ret = {4'b0000, ret_s[k]};
      #1;
      if (grants !== {4'b0000, gnt_s[k]}) begin n_bad++; $display("FAIL credit_cycle%0d: got %b want %b", k, grants, {4'b0000, gnt_s[k]}); end
      n_cmp++;
      @(negedge clk);
      if (err !== 1'b0) begin n_bad++; $display("FAIL credit_err%0d: got %b want 0", k, err); end
      n_cmp++;
    end
    clear_inputs();
  endtask

  task automatic test_errors();
    int cnt;
    do_reset();
    @(negedge clk);
    set_req(2, 3'd6, 1'b1);
    #1;
    if (grants !== 5'b00000) begin n_bad++; $display("FAIL badport_grant: got %b want 00000", grants); end
    n_cmp++;
    @(negedge clk);
    if (err !== 1'b1) begin n_bad++; $display("FAIL badport_err: got %b want 1", err); end
    n_cmp++;
    clear_inputs();
    @(negedge clk);
    if (err !== 1'b0) begin n_bad++; $display("FAIL badport_err_pulse: got %b want 0", err); end
    n_cmp++;
    credit_ret = 5'b01000;
    @(negedge clk);
    if (err !== 1'b1) begin n_bad++; $display("FAIL credit_ovf_err: got %b want 1", err); end
    n_cmp++;
    credit_ret = '0;
    set_req(0, 3'd3, 1'b1);
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (grants[0] === 1'b1) cnt++;
      @(negedge clk);
    end
    if (cnt !== 4) begin n_bad++; $display("FAIL credit_ovf_saturate: got %0d grants want 4", cnt); end
    n_cmp++;
    clear_inputs();
    @(negedge clk);
    set_req(0, 3'd4, 1'b0);
    #1;
    if (grants !== 5'b00001) begin n_bad++; $display("FAIL owner_head: got %b want 00001", grants); end
    n_cmp++;
    @(negedge clk);
    set_req(0, 3'd1, 1'b1);
    #1;
    if (grants !== 5'b00000) begin n_bad++; $display("FAIL owner_wrong_grant: got %b want 00000", grants); end
    n_cmp++;
    @(negedge clk);
    if (err !== 1'b1) begin n_bad++; $display("FAIL owner_wrong_err: got %b want 1", err); end
    n_cmp++;
    if (out_locked !== 5'b10000) begin n_bad++; $display("FAIL owner_wrong_lock: got %b want 10000", out_locked); end
    n_cmp++;
    clear_inputs();
  endtask

  task automatic test_en_reset();
    int cnt;
    do_reset();
    @(negedge clk);
    set_req(1, 3'd3, 1'b0);
    #1;
    if (grants !== 5'b00010) begin n_bad++; $display("FAIL en_head: got %b want 00010", grants); end
    n_cmp++;
    @(negedge clk);
    en = 1'b0;
    #1;
    if (grants !== 5'b00000) begin n_bad++; $display("FAIL en_off_grant: got %b want 00000", grants); end
    n_cmp++;
    if (xbar_on !== 1'b0) begin n_bad++; $display("FAIL en_off_xbar_on: got %b want 0", xbar_on); end
    n_cmp++;
    @(negedge clk);
    if (out_locked !== 5'b01000) begin n_bad++; $display("FAIL en_off_lock: got %b want 01000", out_locked); end
    n_cmp++;
    en = 1'b1;
    #1;
    if (grants !== 5'b00010) begin n_bad++; $display("FAIL en_resume: got %b want 00010", grants); end
    n_cmp++;
    @(negedge clk);
    set_req(1, 3'd3, 1'b1);
    #1;
    if (grants !== 5'b00010) begin n_bad++; $display("FAIL en_tail: got %b want 00010", grants); end
    n_cmp++;
    @(negedge clk);
    if (out_locked !== 5'b00000) begin n_bad++; $display("FAIL en_unlock: got %b want 00000", out_locked); end
    n_cmp++;
    set_req(1, 3'd3, 1'b0);
    @(negedge clk);
    if (out_locked !== 5'b01000) begin n_bad++; $display("FAIL rst_pre_lock: got %b want 01000", out_locked); end
    n_cmp++;
    #2;
    reset = 1'b0;
    #1;
    if (out_locked !== 5'b00000) begin n_bad++; $display("FAIL rst_mid_lock: got %b want 00000", out_locked); end
    n_cmp++;
    if (grants !== 5'b00000) begin n_bad++; $display("FAIL rst_mid_grant: got %b want 00000", grants); end
    n_cmp++;
    clear_inputs();
    @(negedge clk);
    reset = 1'b1;
    set_req(2, 3'd3, 1'b1);
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (grants[2] === 1'b1) cnt++;
      @(negedge clk);
    end
    if (cnt !== 4) begin n_bad++; $display("FAIL rst_credit_restore: got %0d grants want 4", cnt); end
    n_cmp++;
    clear_inputs();
  endtask

  task automatic test_parallel();
    logic [14:0] exp_ports;
    do_reset();
    @(negedge clk);
    set_req(0, 3'd4, 1'b1);
    set_req(1, 3'd3, 1'b1);
    exp_ports = 15'b000_000_000_011_100;
    #1;
    if (grants !== 5'b00011) begin n_bad++; $display("FAIL parallel_grants: got %b want 00011", grants); end
    n_cmp++;
    if (xbar_ports !== exp_ports) begin n_bad++; $display("FAIL parallel_xbar_ports: got %b want %b", xbar_ports, exp_ports); end
    n_cmp++;
    @(negedge clk);
    if (out_locked !== 5'b00000) begin n_bad++; $display("FAIL parallel_locked: got %b want 00000", out_locked); end
    n_cmp++;
    if (err !== 1'b0) begin n_bad++; $display("FAIL parallel_err: got %b want 0", err); end
    n_cmp++;
    clear_inputs();
  endtask

  initial begin
    reset = 1'b0;
    en    = 1'b1;
    clear_inputs();
    test_reset();
    test_contention();
    test_wormhole();
    test_credits();
    test_errors();
    test_en_reset();
    test_parallel();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
